// File: rtl/count_pkg.sv
// count_ndu shared types and defaults.
// Optional prescaler build macro: COUNT_PRESCALE_EN.
package count_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } cnt_dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/count_ndu_if.sv
// Control/status bundle between a counter and its driver.
// Shared by all builds (COUNT_PRESCALE_EN on or off).
interface count_ndu_if
  import count_pkg::*;
#(
  parameter int W = CNT_W_DEF
);

  logic      clr;
  logic      ld;
  logic [W-1:0] d;
  logic      e;
  cnt_dir_e  dir;
  cnt_mode_e sat;
  logic [W-1:0] max;
  logic [W-1:0] q;
  logic      tc;
  logic      ovf;

  modport master (
    output clr, ld, d, e, dir, sat, max,
    input  q, tc, ovf
  );

  modport slave (
    input  clr, ld, d, e, dir, sat, max,
    output q, tc, ovf
  );

endinterface

// File: rtl/count_prescale.sv
// Enable prescaler: ticks on every PRESC-th enabled edge.
// Built only when COUNT_PRESCALE_EN is defined.
module count_prescale #(
  parameter int W     = 8,
  parameter int PRESC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic e,
  output logic tick
);

  localparam logic [W-1:0] LAST = W'(PRESC - 1);

  logic [W-1:0] cnt;

  assign tick = e & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (e) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/count_ndu.sv
// Up/down bounded counter with wrap/saturate, TC pulse, sticky OVF.
// COUNT_PRESCALE_EN: insert count_prescale between E and the step.
module count_ndu
  import count_pkg::*;
#(
  parameter int W     = CNT_W_DEF,
  parameter int PRESC = 4
) (
  input  logic clk,
  input  logic rst_n,
  count_ndu_if.slave bus
);

  logic [W-1:0] q_r, q_n;
  logic tc_r, tc_n;
  logic ovf_r, ovf_n;
  logic step;

`ifdef COUNT_PRESCALE_EN
  count_prescale #(
    .W     (W),
    .PRESC (PRESC)
  ) u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clr | bus.ld),
    .e     (bus.e),
    .tick  (step)
  );
`else
  assign step = bus.e & (PRESC != 0);
`endif

  always_comb begin
    q_n   = q_r;
    tc_n  = 1'b0;
    ovf_n = ovf_r;
    if (bus.clr) begin
      q_n   = '0;
      ovf_n = 1'b0;
    end else if (bus.ld) begin
      q_n = (bus.d > bus.max) ? bus.max : bus.d;
    end else if (step) begin
      // Range check first, so MAX==0 falls into the bound cases below
      if (q_r > bus.max) begin
        if (bus.dir == DIR_UP && bus.sat == MODE_WRAP)
          q_n = '0;
        else
          q_n = bus.max;
      end else if (bus.dir == DIR_UP) begin
        if (q_r == bus.max) begin
          q_n  = (bus.sat == MODE_SAT) ? bus.max : '0;
          tc_n = 1'b1;
        end else begin
          q_n = q_r + 1'b1;
        end
      end else begin
        if (q_r == '0) begin
          q_n  = (bus.sat == MODE_SAT) ? '0 : bus.max;
          tc_n = 1'b1;
        end else begin
          q_n = q_r - 1'b1;
        end
      end
      ovf_n = ovf_r | tc_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r   <= '0;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_n;
      tc_r  <= tc_n;
      ovf_r <= ovf_n;
    end
  end

  assign bus.q   = q_r;
  assign bus.tc  = tc_r;
  assign bus.ovf = ovf_r;

endmodule

// File: tb/tb_count_ndu.sv
// Directed testbench for count_ndu (W=8, PRESC=4).
// Prescale section active when COUNT_PRESCALE_EN is defined.
module tb_count_ndu;
  import count_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_run = 0;
  int n_fail = 0;

  count_ndu_if #(.W(8)) bus ();

  count_ndu #(
    .W     (8),
    .PRESC (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tk(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ld_val(input logic [7:0] v);
    bus.ld = 1'b1;
    bus.d  = v;
    tk();
    bus.ld = 1'b0;
  endtask

  task automatic clr_pulse();
    bus.clr = 1'b1;
    tk();
    bus.clr = 1'b0;
  endtask

  initial begin
    bus.clr = 1'b0;
    bus.ld  = 1'b0;
    bus.d   = '0;
    bus.e   = 1'b0;
    bus.dir = DIR_UP;
    bus.sat = MODE_WRAP;
    bus.max = 8'd99;
    #1;
    chk("rst_q", bus.q, 0);
    chk("rst_tc", bus.tc, 0);
    chk("rst_ovf", bus.ovf, 0);
    tk(2);
    rst_n = 1'b1;

    // count to 37 then async reset between edges
    bus.e = 1'b1;
    tk(37);
    chk("cnt37", bus.q, 37);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q", bus.q, 0);
    chk("arst_tc", bus.tc, 0);
    chk("arst_ovf", bus.ovf, 0);
    bus.dir = DIR_DOWN;
    for (int i = 0; i < 10; i++) begin
      tk();
      chk("rst_hold_q", bus.q, 0);
    end
    bus.e = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tk();
      chk("en_off_q", bus.q, 0);
      chk("en_off_tc", bus.tc, 0);
    end

    // up wrap over 110 edges
    bus.e = 1'b1;
    bus.dir = DIR_UP;
    for (int i = 1; i <= 110; i++) begin
      tk();
      chk("upw_q", bus.q, i % 100);
      chk("upw_tc", bus.tc, (i == 100) ? 1 : 0);
      chk("upw_ovf", bus.ovf, (i >= 100) ? 1 : 0);
    end

    bus.e = 1'b0;
    clr_pulse();
    chk("clr_q", bus.q, 0);
    chk("clr_ovf", bus.ovf, 0);
    bus.dir = DIR_DOWN;
    bus.e = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tk();
      chk("dnw_q", bus.q, 99 - i);
      chk("dnw_tc", bus.tc, (i == 0) ? 1 : 0);
    end
    chk("dnw_ovf", bus.ovf, 1);

    // saturate with load
    bus.e = 1'b0;
    bus.sat = MODE_SAT;
    ld_val(8'd97);
    chk("ld97_q", bus.q, 97);
    chk("ld97_tc", bus.tc, 0);
    bus.dir = DIR_UP;
    bus.e = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tk();
      chk("sat_q", bus.q, (i == 0) ? 98 : 99);
      chk("sat_tc", bus.tc, (i >= 2) ? 1 : 0);
    end
    bus.e = 1'b0;
    ld_val(8'd200);
    chk("ld200_q", bus.q, 99);
    bus.clr = 1'b1;
    bus.ld = 1'b1;
    bus.d = 8'd55;
    bus.e = 1'b1;
    tk();
    bus.clr = 1'b0;
    bus.ld = 1'b0;
    bus.e = 1'b0;
    chk("clrld_q", bus.q, 0);
    chk("clrld_ovf", bus.ovf, 0);

    // out of range after lowering MAX
    bus.sat = MODE_WRAP;
    ld_val(8'd50);
    bus.max = 8'd20;
    bus.dir = DIR_UP;
    bus.e = 1'b1;
    tk();
    bus.e = 1'b0;
    chk("oor_upw_q", bus.q, 0);
    chk("oor_upw_tc", bus.tc, 0);
    bus.max = 8'd99;
    ld_val(8'd50);
    bus.max = 8'd20;
    bus.sat = MODE_SAT;
    bus.e = 1'b1;
    tk();
    bus.e = 1'b0;
    chk("oor_ups_q", bus.q, 20);
    bus.max = 8'd99;
    ld_val(8'd50);
    bus.max = 8'd20;
    bus.dir = DIR_DOWN;
    bus.sat = MODE_WRAP;
    bus.e = 1'b1;
    tk();
    bus.e = 1'b0;
    chk("oor_dn_q", bus.q, 20);
    chk("oor_dn_tc", bus.tc, 0);
    chk("oor_ovf", bus.ovf, 0);

    // MAX=0: every step is a bound event
    bus.max = 8'd0;
    clr_pulse();
    bus.e = 1'b1;
    bus.dir = DIR_UP;
    tk();
    chk("max0_up_q", bus.q, 0);
    chk("max0_up_tc", bus.tc, 1);
    chk("max0_ovf", bus.ovf, 1);
    bus.dir = DIR_DOWN;
    tk();
    chk("max0_dn_q", bus.q, 0);
    chk("max0_dn_tc", bus.tc, 1);
    bus.e = 1'b0;
    tk();
    chk("idle_tc", bus.tc, 0);
    chk("ovf_sticky", bus.ovf, 1);
    bus.max = 8'd99;

`ifdef COUNT_PRESCALE_EN
    clr_pulse();
    bus.dir = DIR_UP;
    bus.e = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tk();
      chk("pre_q", bus.q, i / 4);
    end
    tk(2);
    chk("pre_mid_q", bus.q, 3);
    ld_val(8'd10);
    chk("pre_ld_q", bus.q, 10);
    for (int i = 1; i <= 4; i++) begin
      tk();
      chk("pre_ld_ph", bus.q, (i == 4) ? 11 : 10);
    end
    bus.e = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/count_ndu.md
# count_ndu

Parametrised up/down counter with programmable upper bound, synchronous load/clear, wrap or saturate mode, registered terminal-count pulse and sticky overflow flag. Next generation of the lab counter family: generalised from fixed 8 bits to W bits. Used standalone or cascaded, with TC driving the next stage's E, as the timebase/event counter in later labs.

## Interface
- W, 8, counter width in bits (W >= 2)
- PRESC, 4, enable prescale ratio (W-bit range, >= 1); used only when COUNT_PRESCALE_EN is defined

- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- CLR  in  1  synchronous clear of Q and OVF
- LD  in  1  synchronous load of D into Q
- D  in  W  load value
- E  in  1  count enable
- DIR  in  1  1 = count up, 0 = count down
- SAT  in  1  0 = wrap at bounds, 1 = saturate at bounds
- MAX  in  W  inclusive upper bound; lower bound fixed at 0
- Q  out  W  count value, registered
- TC  out  1  terminal-count pulse, registered
- OVF  out  1  sticky overflow flag, registered

## Operation
- Reset (RST_N=0, asynchronous): Q=0, TC=0, OVF=0, prescaler=0.
- Priority at each edge: CLR > LD > counting (E). E is ignored when CLR or LD is high.
- CLR: Q=0, OVF=0, TC=0.
- LD: Q = min(D, MAX), TC=0, OVF unchanged.
- Step, up, Q<MAX: Q+1.
- Step, up, Q==MAX: wrap mode gives 0; saturate mode holds MAX. TC=1 in either case.
- Step, down, Q>0: Q-1.
- Step, down, Q==0: wrap mode gives MAX; saturate mode holds 0. TC=1 in either case.
- Out of range (Q>MAX after MAX is lowered), on a step: up gives 0 in wrap mode, MAX in saturate mode; down gives MAX. TC is not asserted.
- MAX=0: Q stays 0. Every step is a bound event, so TC=1 on every stepping edge.
- TC=0 on any edge without a bound event.
- OVF: set on the same edge as any TC=1. Cleared only by CLR or reset.
- Arithmetic: W-bit unsigned compares. No modular overflow is ever visible, because bound checks precede the +1/-1.

## Timing
- Q, TC and OVF update on the same rising edge. Latency from E/DIR/LD/CLR/D to outputs is one cycle.
- TC is exactly one cycle wide per bound event. A sustained saturate hold produces TC on every stepping edge.
- DIR, SAT and MAX may change on any cycle. Each is sampled at the edge.
- Reset deassertion is synchronised by the system. The first edge after RST_N rises counts normally.
- Reset mid-count: outputs go to 0 immediately, without waiting for an edge.

## Configuration
- COUNT_PRESCALE_EN defined:
  - E feeds a PRESC-cycle prescaler. A step occurs only on every PRESC-th enabled edge, when the prescaler reaches PRESC-1 and returns to 0.
  - The prescaler is cleared by RST_N, CLR and LD.
  - PRESC=1 behaves identically to the macro-undefined build.
- COUNT_PRESCALE_EN undefined:
  - Every edge with E=1 is a step.
  - No prescaler logic is generated and PRESC is ignored.

## Structure
- Package count_pkg:
  - typedef enum cnt_dir_e {DIR_DOWN=0, DIR_UP=1}
  - typedef enum cnt_mode_e {MODE_WRAP=0, MODE_SAT=1}
  - localparam default width CNT_W_DEF=8
- Sub-module count_prescale (inputs CLK, RST_N, CLR, E; output tick). Instantiated only under COUNT_PRESCALE_EN.
- Top level: one next-state block plus registers for Q, TC and OVF.

## Test plan
Unless noted: W=8, MAX=99, macro undefined.
- Reset: count to 37, pulse RST_N=0 between edges -> Q=0, TC=0, OVF=0 before the next edge. Hold E=1, DIR=0, RST_N=0 for 10 clocks -> Q stays 0.
- Enable off: from Q=0, E=0 for 10 clocks -> Q=0, TC=0.
- Up wrap: E=1, DIR=1, SAT=0, 110 clocks from 0 -> Q = i mod 100. TC=1 only on edge 100 (Q=0). OVF=1 from edge 100 on.
- Down wrap: from Q=0 after CLR, DIR=0, E=1 -> Q=99 with TC=1 on the first edge, then 98, 97, … with TC=0.
- Saturate and load:
  - SAT=1, LD with D=97, then DIR=1 for 5 clocks -> Q = 97, 98, 99, 99, 99, 99, with TC=1 on the last three steps.
  - LD with D=200 -> Q=99.
  - CLR and LD together -> Q=0, OVF=0.
- Prescale: COUNT_PRESCALE_EN defined, PRESC=4, E=1, DIR=1 for 12 clocks from 0 -> Q increments after clocks 4, 8 and 12 only, ending at 3. LD mid-period restarts the 4-cycle phase.
